// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multiply/divide unit: operation encodings, FSM
// state encoding, default iteration count, the divide-by-zero LO value and
// small arithmetic helpers used when preparing operands.
// Optional feature macro used by the files importing this package:
//   MULDIV_DIV_EN - enables the DIV/DIVU datapath.
// -----------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_e;

  localparam int          ITER_DEFAULT = 32;
  localparam logic [31:0] DIV0_LO      = 32'hFFFF_FFFF;

  // Signed variants treat operands as two's complement.
  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  // 32-bit unsigned magnitude; |0x80000000| stays 0x80000000.
  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic sgn);
    if (sgn && x[31]) begin
      return 32'd0 - x;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// Combinational single iteration of the multiply/divide datapath.
//   Multiply: {acc_hi, acc_lo} holds {partial product, remaining multiplier};
//             conditionally add operand to the upper half, then shift right.
//   Divide  : {acc_hi, acc_lo} holds {partial remainder, dividend/quotient};
//             shift left, trial-subtract operand, restore on borrow.
// Macro: MULDIV_DIV_EN - when undefined the divide path and is_div are absent.
// Ports:
//   is_div   in  1   select divide iteration (only with MULDIV_DIV_EN)
//   operand  in  32  multiplicand or divisor magnitude
//   acc_hi   in  32  upper accumulator half
//   acc_lo   in  32  lower accumulator half
//   nxt_hi   out 32  next upper accumulator half
//   nxt_lo   out 32  next lower accumulator half
// -----------------------------------------------------------------------------
module muldiv_step
  import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
  input  logic        is_div,
`endif
  input  logic [31:0] operand,
  input  logic [31:0] acc_hi,
  input  logic [31:0] acc_lo,
  output logic [31:0] nxt_hi,
  output logic [31:0] nxt_lo
);

  logic [32:0] mul_sum_s;

  // Add multiplicand into the upper half when the current multiplier bit is set;
  // the 33rd bit carries into the shifted result.
  always_comb begin
    mul_sum_s = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : 33'd0);
  end

`ifdef MULDIV_DIV_EN
  logic [32:0] div_shift_s;
  logic [33:0] div_diff_s;

  // Shift next dividend bit into the remainder and trial-subtract the divisor.
  always_comb begin
    div_shift_s = {acc_hi, acc_lo[31]};
    div_diff_s  = {1'b0, div_shift_s} - {2'b00, operand};
  end
`endif

  // Select the iteration result for the active operation.
  always_comb begin
    {nxt_hi, nxt_lo} = {mul_sum_s, acc_lo[31:1]};
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      if (!div_diff_s[33]) begin
        nxt_hi = div_diff_s[31:0];
        nxt_lo = {acc_lo[30:0], 1'b1};
      end else begin
        nxt_hi = div_shift_s[31:0];
        nxt_lo = {acc_lo[30:0], 1'b0};
      end
    end else begin
      {nxt_hi, nxt_lo} = {mul_sum_s, acc_lo[31:1]};
    end
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Sequence: IDLE -> PREP (magnitudes, result signs) -> RUN (ITER iterations)
// -> FIX (sign correction, HI/LO write, done pulse) -> IDLE.
// Macro: MULDIV_DIV_EN - when undefined DIV/DIVU starts are ignored and the
// divider datapath is not built.
// Ports:
//   clk      in  1   clock, rising edge
//   rst_n    in  1   synchronous active-low reset
//   start_i  in  1   launch op_i (sampled in IDLE only)
//   op_i     in  2   0 MULT, 1 MULTU, 2 DIV, 3 DIVU
//   rs_i     in  32  multiplicand / dividend
//   rt_i     in  32  multiplier / divisor
//   hi_we_i  in  1   MTHI strobe
//   lo_we_i  in  1   MTLO strobe
//   wd_i     in  32  MTHI/MTLO data
//   busy_o   out 1   operation in flight
//   done_o   out 1   one-cycle pulse when HI/LO take a result
//   hi_o     out 32  HI register
//   lo_o     out 32  LO register
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] wd_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int               CNT_W    = $clog2(ITER) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_e           state_r, next_state_s;
  op_e              op_r;
  logic [31:0]      rs_r, opnd_r, acc_hi_r, acc_lo_r, hi_r, lo_r;
  logic [CNT_W-1:0] cnt_r;
  logic             neg_q_r, busy_r, done_r;
`ifdef MULDIV_DIV_EN
  logic             neg_r_r;
`endif
  logic             accept_s, hi_wr_s, lo_wr_s, sgn_s;
  logic [31:0]      step_hi_s, step_lo_s, res_hi_s, res_lo_s;
  logic [63:0]      prod_s;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = accept_s ? PREP : IDLE;
      PREP:    next_state_s = RUN;
      RUN:     next_state_s = (cnt_r == CNT_LAST) ? FIX : RUN;
      FIX:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Control decode: start acceptance and MTHI/MTLO enables (start has priority).
  always_comb begin
    sgn_s = is_signed_op(op_r);
`ifdef MULDIV_DIV_EN
    accept_s = (state_r == IDLE) && start_i;
`else
    accept_s = (state_r == IDLE) && start_i && !op_i[1];
`endif
    hi_wr_s = (state_r == IDLE) && !start_i && hi_we_i;
    lo_wr_s = (state_r == IDLE) && !start_i && lo_we_i;
  end

  muldiv_step u_step (
`ifdef MULDIV_DIV_EN
    .is_div  (op_r[1]),
`endif
    .operand (opnd_r),
    .acc_hi  (acc_hi_r),
    .acc_lo  (acc_lo_r),
    .nxt_hi  (step_hi_s),
    .nxt_lo  (step_lo_s)
  );

  // Sign correction of the finished accumulator into HI/LO values.
  always_comb begin
    if (neg_q_r) begin
      prod_s = 64'd0 - {acc_hi_r, acc_lo_r};
    end else begin
      prod_s = {acc_hi_r, acc_lo_r};
    end
    res_hi_s = prod_s[63:32];
    res_lo_s = prod_s[31:0];
`ifdef MULDIV_DIV_EN
    if (op_r[1]) begin
      // opnd_r holds |rt|, which is zero only for a zero divisor.
      if (opnd_r == 32'd0) begin
        res_hi_s = rs_r;
        res_lo_s = DIV0_LO;
      end else begin
        res_lo_s = neg_q_r ? (32'd0 - acc_lo_r) : acc_lo_r;
        res_hi_s = neg_r_r ? (32'd0 - acc_hi_r) : acc_hi_r;
      end
    end else begin
      res_hi_s = prod_s[63:32];
      res_lo_s = prod_s[31:0];
    end
`endif
  end

  // Datapath, counter, sign latches, HI/LO and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r     <= OP_MULT;
      rs_r     <= 32'd0;
      opnd_r   <= 32'd0;
      acc_hi_r <= 32'd0;
      acc_lo_r <= 32'd0;
      cnt_r    <= '0;
      neg_q_r  <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r_r  <= 1'b0;
`endif
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (next_state_s != IDLE);
      done_r <= (state_r == FIX);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r   <= op_e'(op_i);
            rs_r   <= rs_i;
            opnd_r <= rt_i;
          end else begin
            if (hi_wr_s) hi_r <= wd_i;
            if (lo_wr_s) lo_r <= wd_i;
          end
        end
        PREP: begin
          neg_q_r  <= sgn_s && (rs_r[31] ^ opnd_r[31]);
`ifdef MULDIV_DIV_EN
          neg_r_r  <= sgn_s && rs_r[31];
`endif
          acc_hi_r <= 32'd0;
          cnt_r    <= '0;
          // Divide shifts the dividend out of acc_lo; multiply shifts the multiplier.
          if (op_r[1]) begin
            acc_lo_r <= magnitude(rs_r, sgn_s);
            opnd_r   <= magnitude(opnd_r, sgn_s);
          end else begin
            acc_lo_r <= magnitude(opnd_r, sgn_s);
            opnd_r   <= magnitude(rs_r, sgn_s);
          end
        end
        RUN: begin
          acc_hi_r <= step_hi_s;
          acc_lo_r <= step_lo_s;
          cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        FIX: begin
          hi_r <= res_hi_s;
          lo_r <= res_lo_s;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign busy_o = busy_r;
  assign done_o = done_r;
  assign hi_o   = hi_r;
  assign lo_o   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed self-checking bench for muldiv_unit. Expected values are
// hand-computed constants. DIV/DIVU results are checked when MULDIV_DIV_EN is
// defined; otherwise DIV/DIVU starts are checked to be ignored.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, start_i, hi_we_i, lo_we_i;
  logic [1:0]  op_i;
  logic [31:0] rs_i, rt_i, wd_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .op_i    (op_i),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .hi_we_i (hi_we_i),
    .lo_we_i (lo_we_i),
    .wd_i    (wd_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and observe 40 edges; reports busy count, done count,
  // edge index of the done pulse and whether HI/LO held while busy.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int busy_cyc, output int done_cnt, output int done_at,
                       output logic held);
    logic [31:0] h0, l0;
    h0 = hi_o; l0 = lo_o; held = 1'b1;
    busy_cyc = 0; done_cnt = 0; done_at = -1;
    start_i = 1'b1; op_i = op; rs_i = a; rt_i = b;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) begin
        start_i = 1'b0; op_i = ~op; rs_i = ~a; rt_i = ~b;
      end
      if (busy_o) begin
        busy_cyc++;
        if (hi_o !== h0 || lo_o !== l0) held = 1'b0;
      end
      if (done_o) begin
        done_cnt++;
        done_at = i;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
    checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi_o); end
    checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo_o); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mult_signed();
    int bc, dc, da; logic held;
    do_op(2'd0, 32'hFFFF_FFFE, 32'd3, bc, dc, da, held);
    checks++; if (bc !== 34) begin errors++; $display("FAIL mult_busy_cycles got %0d want 34", bc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL mult_done_pulses got %0d want 1", dc); end
    checks++; if (da !== 34) begin errors++; $display("FAIL mult_done_edge got %0d want 34", da); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL mult_hold_while_busy got %b want 1", held); end
    checks++; if (hi_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi_o); end
    checks++; if (lo_o !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", lo_o); end
  endtask

  task automatic test_mult_patterns();
    int bc, dc, da; logic held;
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc, da, held);
    checks++; if (hi_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_max_hi got %h want fffffffe", hi_o); end
    checks++; if (lo_o !== 32'h0000_0001) begin errors++; $display("FAIL multu_max_lo got %h want 00000001", lo_o); end
    do_op(2'd1, 32'h1234_5678, 32'h10, bc, dc, da, held);
    checks++; if (hi_o !== 32'h0000_0001) begin errors++; $display("FAIL multu_shift_hi got %h want 00000001", hi_o); end
    checks++; if (lo_o !== 32'h2345_6780) begin errors++; $display("FAIL multu_shift_lo got %h want 23456780", lo_o); end
    do_op(2'd0, 32'h8000_0000, 32'h8000_0000, bc, dc, da, held);
    checks++; if (hi_o !== 32'h4000_0000) begin errors++; $display("FAIL mult_minsq_hi got %h want 40000000", hi_o); end
    checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL mult_minsq_lo got %h want 0", lo_o); end
    do_op(2'd0, 32'hFFFF_FFFF, 32'd1, bc, dc, da, held);
    checks++; if (hi_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg1_hi got %h want ffffffff", hi_o); end
    checks++; if (lo_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg1_lo got %h want ffffffff", lo_o); end
  endtask

  task automatic test_div();
    int bc, dc, da; logic held;
`ifdef MULDIV_DIV_EN
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, bc, dc, da, held);
    checks++; if (lo_o !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg7_lo got %h want fffffffd", lo_o); end
    checks++; if (hi_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg7_hi got %h want ffffffff", hi_o); end
    do_op(2'd3, 32'd7, 32'd2, bc, dc, da, held);
    checks++; if (lo_o !== 32'd3) begin errors++; $display("FAIL divu_7_lo got %h want 3", lo_o); end
    checks++; if (hi_o !== 32'd1) begin errors++; $display("FAIL divu_7_hi got %h want 1", hi_o); end
    do_op(2'd2, 32'd100, 32'hFFFF_FFF9, bc, dc, da, held);
    checks++; if (lo_o !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_100_lo got %h want fffffff2", lo_o); end
    checks++; if (hi_o !== 32'd2) begin errors++; $display("FAIL div_100_hi got %h want 2", hi_o); end
    do_op(2'd2, 32'h0000_1234, 32'd0, bc, dc, da, held);
    checks++; if (hi_o !== 32'h0000_1234) begin errors++; $display("FAIL div0_hi got %h want 00001234", hi_o); end
    checks++; if (lo_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo got %h want ffffffff", lo_o); end
    checks++; if (bc !== 34) begin errors++; $display("FAIL div0_busy_cycles got %0d want 34", bc); end
    do_op(2'd3, 32'hFFFF_FFFF, 32'd0, bc, dc, da, held);
    checks++; if (hi_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_hi got %h want ffffffff", hi_o); end
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc, da, held);
    checks++; if (lo_o !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", lo_o); end
    checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want 0", hi_o); end
`else
    // HI/LO are ffffffff/ffffffff from the last multiply.
    do_op(2'd2, 32'd7, 32'd2, bc, dc, da, held);
    checks++; if (bc !== 0) begin errors++; $display("FAIL div_off_busy got %0d want 0", bc); end
    checks++; if (dc !== 0) begin errors++; $display("FAIL div_off_done got %0d want 0", dc); end
    checks++; if (hi_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_off_hi got %h want ffffffff", hi_o); end
    checks++; if (lo_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_off_lo got %h want ffffffff", lo_o); end
    do_op(2'd3, 32'd7, 32'd2, bc, dc, da, held);
    checks++; if (bc !== 0 || dc !== 0) begin errors++; $display("FAIL divu_off_activity got busy %0d done %0d want 0 0", bc, dc); end
    checks++; if (lo_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_off_lo got %h want ffffffff", lo_o); end
`endif
  endtask

  task automatic test_mthi_mtlo();
    hi_we_i = 1'b1; lo_we_i = 1'b1; wd_i = 32'h1234_5678;
    tick();
    hi_we_i = 1'b0; lo_we_i = 1'b0;
    checks++; if (hi_o !== 32'h1234_5678) begin errors++; $display("FAIL mt_both_hi got %h want 12345678", hi_o); end
    checks++; if (lo_o !== 32'h1234_5678) begin errors++; $display("FAIL mt_both_lo got %h want 12345678", lo_o); end
    lo_we_i = 1'b1; wd_i = 32'h5A5A_5A5A;
    tick();
    lo_we_i = 1'b0;
    checks++; if (lo_o !== 32'h5A5A_5A5A) begin errors++; $display("FAIL mtlo_lo got %h want 5a5a5a5a", lo_o); end
    checks++; if (hi_o !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi_kept got %h want 12345678", hi_o); end
    // start together with MTHI: start wins, write dropped
    start_i = 1'b1; op_i = 2'd1; rs_i = 32'd2; rt_i = 32'd2; hi_we_i = 1'b1; wd_i = 32'hFFFF_0000;
    tick();
    start_i = 1'b0; hi_we_i = 1'b0;
    checks++; if (hi_o !== 32'h1234_5678) begin errors++; $display("FAIL start_vs_mthi_hi got %h want 12345678", hi_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL start_vs_mthi_busy got %b want 1", busy_o); end
    for (int i = 0; i < 40; i++) tick();
    checks++; if (hi_o !== 32'd0 || lo_o !== 32'd4) begin errors++; $display("FAIL start_vs_mthi_result got %h_%h want 00000000_00000004", hi_o, lo_o); end
  endtask

  task automatic test_robust();
    int bc, dc;
    hi_we_i = 1'b1; wd_i = 32'hA5A5_A5A5;
    tick();
    hi_we_i = 1'b0;
    checks++; if (hi_o !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi_hi got %h want a5a5a5a5", hi_o); end
    checks++; if (lo_o !== 32'd4) begin errors++; $display("FAIL mthi_lo_kept got %h want 4", lo_o); end
    // MULT 5x6 with a stray start + MTLO pulse while busy
    bc = 0; dc = 0;
    start_i = 1'b1; op_i = 2'd0; rs_i = 32'd5; rt_i = 32'd6;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) begin
        start_i = 1'b0;
      end else if (i == 4) begin
        start_i = 1'b1; lo_we_i = 1'b1; wd_i = 32'h1111_1111; op_i = 2'd1; rs_i = 32'd7; rt_i = 32'd7;
      end else if (i == 5) begin
        start_i = 1'b0; lo_we_i = 1'b0;
      end else begin
        wd_i = wd_i;
      end
      if (busy_o) bc++;
      if (done_o) dc++;
    end
    checks++; if (bc !== 34) begin errors++; $display("FAIL busy_ignore_cycles got %0d want 34", bc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL busy_ignore_done got %0d want 1", dc); end
    checks++; if (hi_o !== 32'd0) begin errors++; $display("FAIL busy_ignore_hi got %h want 0", hi_o); end
    checks++; if (lo_o !== 32'd30) begin errors++; $display("FAIL busy_ignore_lo got %h want 1e", lo_o); end
    // restart, then reset at the 10th edge
    start_i = 1'b1; op_i = 2'd0; rs_i = 32'd3; rt_i = 32'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) start_i = 1'b0;
    end
    rst_n = 1'b0;
    tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrun_reset_busy got %b want 0", busy_o); end
    checks++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin errors++; $display("FAIL midrun_reset_hilo got %h_%h want 0_0", hi_o, lo_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL midrun_reset_done got %b want 0", done_o); end
    rst_n = 1'b1;
    bc = 0; dc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy_o) bc++;
      if (done_o) dc++;
    end
    checks++; if (bc !== 0 || dc !== 0) begin errors++; $display("FAIL post_reset_activity got busy %0d done %0d want 0 0", bc, dc); end
    checks++; if (lo_o !== 32'd0) begin errors++; $display("FAIL post_reset_lo got %h want 0", lo_o); end
  endtask

  task automatic test_back_to_back();
    int first_at, second_at;
    first_at = -1; second_at = -1;
    start_i = 1'b1; op_i = 2'd1; rs_i = 32'd6; rt_i = 32'd7;
    for (int i = 0; i < 40 && first_at < 0; i++) begin
      tick();
      if (i == 0) start_i = 1'b0;
      if (done_o) first_at = i;
    end
    checks++; if (first_at !== 34) begin errors++; $display("FAIL b2b_first_edge got %0d want 34", first_at); end
    checks++; if (lo_o !== 32'd42) begin errors++; $display("FAIL b2b_first_lo got %h want 2a", lo_o); end
    // first IDLE cycle: launch the next operation
    start_i = 1'b1; op_i = 2'd0; rs_i = 32'hFFFF_FFFF; rt_i = 32'hFFFF_FFFF;
    for (int j = 1; j <= 45 && second_at < 0; j++) begin
      tick();
      if (j == 1) start_i = 1'b0;
      if (done_o) second_at = j;
    end
    checks++; if (second_at !== 35) begin errors++; $display("FAIL b2b_second_edge got %0d want 35", second_at); end
    checks++; if (hi_o !== 32'd0 || lo_o !== 32'd1) begin errors++; $display("FAIL b2b_second_result got %h_%h want 00000000_00000001", hi_o, lo_o); end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
    op_i = 2'd0; rs_i = 32'd0; rt_i = 32'd0; wd_i = 32'd0;
    test_reset();
    test_mult_signed();
    test_mult_patterns();
    test_div();
    test_mthi_mtlo();
    test_robust();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS core. It consumes the two register-file read operands (rs, rt) for MULT/MULTU/DIV/DIVU and updates HI/LO after a fixed latency. It serves MTHI/MTLO writes. It drives hi_o/lo_o into the write-back mux, so MFHI/MFLO results return to the register-file write port. The core stalls on busy_o.

## Interface
- ITER, 32: iteration count, one result bit per cycle.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start_i  in  1  launch the operation selected by op_i; sampled only in IDLE.
- op_i  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- rs_i  in  32  operand A: multiplicand or dividend.
- rt_i  in  32  operand B: multiplier or divisor.
- hi_we_i  in  1  MTHI write strobe.
- lo_we_i  in  1  MTLO write strobe.
- wd_i  in  32  MTHI/MTLO data.
- busy_o  out  1  operation in flight; reset 0.
- done_o  out  1  one-cycle pulse when HI/LO receive a result; reset 0.
- hi_o  out  32  HI register; reset 0.
- lo_o  out  32  LO register; reset 0.

## Operation
- States:
  - IDLE: start_i=1 latches operands and op, then goes to PREP.
  - PREP: forms operand magnitudes (signed ops) and records the result signs, then goes to RUN with the counter cleared.
  - RUN: performs ITER iterations, then goes to FIX.
  - FIX: applies sign correction, writes HI/LO, pulses done_o, then returns to IDLE.
- Multiply: radix-2 shift-add on the magnitudes, giving a 64-bit product.
  - Signed: product is negated when the operand signs differ.
  - HI = product[63:32], LO = product[31:0].
- Divide: restoring division on the magnitudes.
  - LO = quotient, HI = remainder.
  - Signed: quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
- Magnitudes are 32-bit unsigned, so |0x80000000| = 0x80000000. The DIV case 0x80000000 / -1 therefore yields LO=0x80000000, HI=0.
- Divide by zero (rt=0, signed or unsigned): HI = rs_i as latched, LO = 0xFFFFFFFF. The operation still takes full latency.
- MTHI/MTLO in IDLE: register is written at the edge; hi_we_i and lo_we_i are independent.
- Priority and ignored inputs:
  - start_i together with hi_we_i/lo_we_i in IDLE: start wins and the writes are dropped.
  - start_i, hi_we_i and lo_we_i are ignored while busy_o=1.
  - op_i, rs_i and rt_i are don't-care after the start edge.
- hi_o/lo_o hold their previous values while busy and change only at the FIX edge.

## Timing
- Launch: start_i sampled high at edge E0 with state IDLE.
- busy_o is high after E0 through E34 inclusive of the FIX cycle, i.e. 34 cycles. It is low after E34.
- hi_o/lo_o update at edge E34.
- done_o is high for exactly the cycle following E34.
- Back-to-back: a new start_i may be sampled at E35, the first IDLE cycle. The next result lands at E69.
- Reset: rst_n=0 at any edge, including mid-RUN, forces IDLE. busy_o, done_o, hi_o, lo_o and the counter are all 0 after that edge. No partial result is written.
- No combinational path from start_i, op_i, rs_i or rt_i to any output.

## Configuration
- MULDIV_DIV_EN defined: DIV/DIVU implemented as above.
- Without MULDIV_DIV_EN:
  - The divider datapath is removed.
  - start_i with op_i = 2 or 3 is ignored: no state change, busy_o stays 0, HI/LO unchanged, no done_o.
  - MULT/MULTU and MTHI/MTLO are unaffected.

## Structure
- Shared package muldiv_pkg:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - state enum (IDLE, PREP, RUN, FIX);
  - ITER default;
  - DIV0_LO constant 0xFFFFFFFF.
- One sub-module, muldiv_step: combinational single iteration.
  - Multiply: conditional add plus shift.
  - Divide: trial subtract, restore, quotient-bit shift.
  - Instanced once and used every RUN cycle.
- FSM, counter, sign latches and HI/LO registers live in muldiv_unit.

## Test plan
- MULT rs=0xFFFFFFFE, rt=3: busy_o high 34 cycles → HI=0xFFFFFFFF, LO=0xFFFFFFFA, done_o one pulse.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=-7, rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=7, rt=2 → LO=3, HI=1.
- DIV rs=0x00001234, rt=0 → HI=0x00001234, LO=0xFFFFFFFF.
- DIV rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0.
- Robustness sequence:
  - MTHI 0xA5A5A5A5 in IDLE → hi_o=0xA5A5A5A5 next cycle.
  - start MULT 5×6, then pulse start_i and lo_we_i at cycle 5 → both ignored; result HI=0, LO=30.
  - Restart and assert rst_n=0 at cycle 10 → busy_o=0, hi_o=lo_o=0 after that edge, and no done_o.
